// File: rtl/attack_pkg.sv
// attack_pkg: facing/orientation encodings, park coordinate, slot FSM state type and coordinate helpers
package attack_pkg;
  typedef enum logic [1:0] {
    FACE_UP    = 2'b00,
    FACE_DOWN  = 2'b01,
    FACE_LEFT  = 2'b10,
    FACE_RIGHT = 2'b11
  } facing_t;
  localparam logic ORIENT_VERT = 1'b0;
  localparam logic ORIENT_HORZ = 1'b1;
  localparam logic [11:0] PARK_POS = 12'd4000;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } slot_state_t;
  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction
  function automatic logic [11:0] clamp_sub(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? a - b : 12'd0;
  endfunction
endpackage

// File: rtl/attack_if.sv
// attack_if: game-logic/draw-pipeline side signals of the attack sequencer, packed {P1,P0}
interface attack_if;
  logic        vsync_in;
  logic [1:0]  fire;
  logic [3:0]  facing;
  logic [23:0] player_x;
  logic [23:0] player_y;
  logic [23:0] x_pos;
  logic [23:0] y_pos;
  logic        direction;
  logic [1:0]  attack_active;
  modport master (
    output vsync_in, fire, facing, player_x, player_y,
    input  x_pos, y_pos, direction, attack_active
  );
  modport slave (
    input  vsync_in, fire, facing, player_x, player_y,
    output x_pos, y_pos, direction, attack_active
  );
endinterface

// File: rtl/attack_slot.sv
// attack_slot: one player's fire capture, ACTIVE/COOLDOWN sequencer and rectangle placement
module attack_slot
  import attack_pkg::*;
#(
  parameter int ACTIVE_FRAMES   = 8,
  parameter int COOLDOWN_FRAMES = 16,
  parameter int SPRITE_SIZE     = 60,
  parameter int RECT_LONG       = 40,
  parameter int RECT_SHORT      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        fire,
  input  logic        grant,
  input  logic [1:0]  facing,
  input  logic [11:0] px,
  input  logic [11:0] py,
  output logic        idle,
  output logic        active,
  output logic        pend,
  output logic        orient,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos
);
  localparam logic [11:0] SIDE = 12'(SPRITE_SIZE);
  localparam logic [11:0] LONG = 12'(RECT_LONG);
  localparam logic [11:0] MID  = 12'((SPRITE_SIZE - RECT_SHORT) / 2);
  localparam logic [7:0]  ACT_LOAD = 8'(ACTIVE_FRAMES - 1);
  localparam logic [7:0]  CD_LOAD  = 8'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);
  slot_state_t state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  face_q, face_n;
  logic        fire_q, pend_n;
  logic [11:0] x_n, y_n;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    face_n  = face_q;
    if (tick)
      case (state)
        IDLE: if (pend && grant) begin
          state_n = ACTIVE;
          cnt_n   = ACT_LOAD;
          face_n  = facing;
        end
        ACTIVE: if (cnt == 8'd0) begin
          state_n = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
          cnt_n   = CD_LOAD;
        end else cnt_n = cnt - 8'd1;
        COOLDOWN: if (cnt == 8'd0) state_n = IDLE;
                  else cnt_n = cnt - 8'd1;
        default: state_n = IDLE;
      endcase
    // a press only registers as a request while idle; every frame tick consumes it
    pend_n = tick ? 1'b0 : pend | (fire & ~fire_q & (state == IDLE));
    x_n = (state_n != ACTIVE)     ? PARK_POS :
          (face_n == FACE_RIGHT)  ? sat_add(px, SIDE) :
          (face_n == FACE_LEFT)   ? clamp_sub(px, LONG) : sat_add(px, MID);
    y_n = (state_n != ACTIVE)     ? PARK_POS :
          (face_n == FACE_UP)     ? clamp_sub(py, LONG) :
          (face_n == FACE_DOWN)   ? sat_add(py, SIDE) : sat_add(py, MID);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      face_q <= 2'b00;
      fire_q <= 1'b0;
      pend   <= 1'b0;
      x_pos  <= PARK_POS;
      y_pos  <= PARK_POS;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      face_q <= face_n;
      fire_q <= fire;
      pend   <= pend_n;
      if (tick) begin
        x_pos <= x_n;
        y_pos <= y_n;
      end
    end
  end
  assign idle   = state == IDLE;
  assign active = state == ACTIVE;
  assign orient = face_q[1];
endmodule

// File: rtl/attack_ctrl.sv
// attack_ctrl: frame-tick detection, arbitration of the shared direction bit, two attack slots
module attack_ctrl
  import attack_pkg::*;
#(
  parameter int ACTIVE_FRAMES   = 8,
  parameter int COOLDOWN_FRAMES = 16,
  parameter int SPRITE_SIZE     = 60,
  parameter int RECT_LONG       = 40,
  parameter int RECT_SHORT      = 20
) (
  input logic     clk,
  input logic     rst_n,
  attack_if.slave bus
);
  logic             vsync_q, tick, dir_q;
  logic [1:0]       idle, active, pend, orient, req_o, grant;
  logic [1:0][11:0] x_p, y_p;
  assign tick = bus.vsync_in & ~vsync_q;
  for (genvar i = 0; i < 2; i++) begin : g_slot
    assign req_o[i] = bus.facing[2*i+1];
    attack_slot #(
      .ACTIVE_FRAMES  (ACTIVE_FRAMES),
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
      .SPRITE_SIZE    (SPRITE_SIZE),
      .RECT_LONG      (RECT_LONG),
      .RECT_SHORT     (RECT_SHORT)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .fire  (bus.fire[i]),
      .grant (grant[i]),
      .facing(bus.facing[2*i +: 2]),
      .px    (bus.player_x[12*i +: 12]),
      .py    (bus.player_y[12*i +: 12]),
      .idle  (idle[i]),
      .active(active[i]),
      .pend  (pend[i]),
      .orient(orient[i]),
      .x_pos (x_p[i]),
      .y_pos (y_p[i])
    );
  end
  // P1 also loses when P0 is granted this tick with the other orientation
  assign grant[0] = pend[0] & idle[0] & (~active[1] | (orient[1] == req_o[0]));
  assign grant[1] = pend[1] & idle[1] & (~active[0] | (orient[0] == req_o[1])) &
                    ~(grant[0] & (req_o[0] != req_o[1]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      dir_q   <= ORIENT_HORZ;
    end else begin
      vsync_q <= bus.vsync_in;
      if (tick && grant[0]) dir_q <= req_o[0];
      else if (tick && grant[1]) dir_q <= req_o[1];
    end
  end
  assign bus.x_pos         = {x_p[1], x_p[0]};
  assign bus.y_pos         = {y_p[1], y_p[0]};
  assign bus.direction     = dir_q;
  assign bus.attack_active = active;
endmodule

// File: tb/tb_attack_ctrl.sv
// tb_attack_ctrl: frame-level model of the attack sequencer checked every cycle, plus directed literal checks
module tb_attack_ctrl;
  import attack_pkg::*;
  localparam int AF = 8;
  localparam int CF = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  attack_if bus();
  attack_ctrl #(
    .ACTIVE_FRAMES(AF), .COOLDOWN_FRAMES(CF), .SPRITE_SIZE(60), .RECT_LONG(40), .RECT_SHORT(20)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  int act[2], cd[2], n_act;
  bit pend[2], fprev[2], ok[2], o[2], vprev;
  logic [1:0]  lfac[2];
  logic        m_dir;
  logic [11:0] mx[2], my[2];
  function automatic logic [11:0] sat(input int v);
    return (v < 0) ? 12'd0 : (v > 4095) ? 12'd4095 : 12'(v);
  endfunction
  function automatic void place(input logic [1:0] f, input int px, input int py,
                                output logic [11:0] x, output logic [11:0] y);
    case (f)
      2'b11:   begin x = sat(px + 60); y = sat(py + 20); end
      2'b10:   begin x = sat(px - 40); y = sat(py + 20); end
      2'b00:   begin x = sat(px + 20); y = sat(py - 40); end
      default: begin x = sat(px + 20); y = sat(py + 60); end
    endcase
  endfunction
  task automatic cmp(input string n, input logic [47:0] a, input logic [47:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; cd[i] = 0; pend[i] = 0; fprev[i] = 0; lfac[i] = 2'b00;
      mx[i] = PARK_POS; my[i] = PARK_POS;
    end
    vprev = 0;
    m_dir = 1'b1;
  endtask
  // advances the model by the clock edge that is about to sample the current inputs
  task automatic model_step();
    if (bus.vsync_in && !vprev) begin
      for (int i = 0; i < 2; i++) begin
        o[i]  = bus.facing[2*i+1];
        ok[i] = pend[i] && (act[1-i] == 0 || lfac[1-i][1] == o[i]);
      end
      if (ok[0] && ok[1] && o[0] != o[1]) ok[1] = 0;
      for (int i = 0; i < 2; i++) begin
        if (act[i] > 0) begin
          act[i]--;
          if (act[i] == 0) cd[i] = CF;
        end else if (cd[i] > 0) cd[i]--;
        if (ok[i]) begin
          act[i]  = AF;
          lfac[i] = bus.facing[2*i +: 2];
        end
        if (act[i] > 0)
          place(lfac[i], int'(bus.player_x[12*i +: 12]), int'(bus.player_y[12*i +: 12]), mx[i], my[i]);
        else begin
          mx[i] = PARK_POS;
          my[i] = PARK_POS;
        end
        pend[i] = 0;
      end
      if (ok[0]) m_dir = o[0];
      else if (ok[1]) m_dir = o[1];
    end else
      for (int i = 0; i < 2; i++)
        if (bus.fire[i] && !fprev[i] && act[i] == 0 && cd[i] == 0) pend[i] = 1;
    for (int i = 0; i < 2; i++) fprev[i] = bus.fire[i];
    vprev = bus.vsync_in;
  endtask
  task automatic cyc();
    if (rst_n) model_step();
    @(negedge clk);
    cmp("model_x", 48'(bus.x_pos), 48'({mx[1], mx[0]}));
    cmp("model_y", 48'(bus.y_pos), 48'({my[1], my[0]}));
    cmp("model_dir", 48'(bus.direction), 48'(m_dir));
    cmp("model_act", 48'(bus.attack_active), 48'({act[1] > 0, act[0] > 0}));
  endtask
  task automatic frame();
    bus.vsync_in = 1'b0;
    repeat (5) cyc();
    bus.vsync_in = 1'b1;
    repeat (3) cyc();
    bus.vsync_in = 1'b0;
  endtask
  task automatic frames(input int n);
    repeat (n) frame();
  endtask
  task automatic set_p(input int i, input logic [1:0] f, input logic [11:0] x, input logic [11:0] y);
    bus.facing[2*i +: 2]    = f;
    bus.player_x[12*i +: 12] = x;
    bus.player_y[12*i +: 12] = y;
  endtask
  initial begin
    bus.vsync_in = 1'b0; bus.fire = 2'b00; bus.facing = 4'h0;
    bus.player_x = 24'h0; bus.player_y = 24'h0;
    model_reset();
    repeat (3) @(negedge clk);
    cmp("rst_x", 48'(bus.x_pos), 48'h000000FA0FA0);
    cmp("rst_dir", 48'(bus.direction), 48'd1);
    cmp("rst_act", 48'(bus.attack_active), 48'd0);
    rst_n = 1'b1;
    frames(2);
    // single attack, then cooldown press is ignored
    set_p(0, 2'b11, 12'd100, 12'd200);
    set_p(1, 2'b00, 12'd500, 12'd500);
    bus.fire = 2'b01;
    frame();
    cmp("a_x0", 48'(bus.x_pos[11:0]), 48'd160);
    cmp("a_y0", 48'(bus.y_pos[11:0]), 48'd220);
    cmp("a_dir", 48'(bus.direction), 48'd1);
    cmp("a_act", 48'(bus.attack_active), 48'd1);
    cmp("a_park1", 48'({bus.x_pos[23:12], bus.y_pos[23:12]}), 48'hFA0FA0);
    bus.fire = 2'b00;
    frames(7);
    cmp("a_act_last", 48'(bus.attack_active), 48'd1);
    frame();
    cmp("a_parked", 48'({bus.x_pos, bus.y_pos}), 48'hFA0FA0FA0FA0);
    cmp("a_act_off", 48'(bus.attack_active), 48'd0);
    bus.fire = 2'b01;
    frame();
    cmp("a_cool_ign", 48'(bus.attack_active), 48'd0);
    bus.fire = 2'b00;
    frames(16);
    // conflicting orientations on the same tick
    bus.fire = 2'b11;
    frame();
    cmp("b_act", 48'(bus.attack_active), 48'd1);
    cmp("b_dir", 48'(bus.direction), 48'd1);
    cmp("b_park1", 48'({bus.x_pos[23:12], bus.y_pos[23:12]}), 48'hFA0FA0);
    bus.fire = 2'b00;
    cyc();
    bus.fire = 2'b10;
    frame();
    cmp("b_refire", 48'(bus.attack_active), 48'd1);
    bus.fire = 2'b00;
    frames(24);
    // same orientation: both granted, P0 clamped at 0
    set_p(0, 2'b10, 12'd20, 12'd50);
    set_p(1, 2'b10, 12'd300, 12'd50);
    bus.fire = 2'b11;
    frame();
    cmp("c_x", 48'(bus.x_pos), 48'({12'd260, 12'd0}));
    cmp("c_y", 48'(bus.y_pos), 48'({12'd70, 12'd70}));
    cmp("c_dir", 48'(bus.direction), 48'd1);
    cmp("c_act", 48'(bus.attack_active), 48'd3);
    bus.fire = 2'b00;
    frames(25);
    // tracking a moving player, vertical rectangle
    set_p(0, 2'b01, 12'd100, 12'd100);
    set_p(1, 2'b00, 12'd500, 12'd500);
    bus.fire = 2'b01;
    frame();
    cmp("d_x0", 48'(bus.x_pos[11:0]), 48'd120);
    cmp("d_y0", 48'(bus.y_pos[11:0]), 48'd160);
    cmp("d_dir", 48'(bus.direction), 48'd0);
    bus.fire = 2'b00;
    bus.player_y[11:0] = 12'd140;
    repeat (3) cyc();
    cmp("d_hold", 48'(bus.y_pos[11:0]), 48'd160);
    frame();
    cmp("d_track", 48'(bus.y_pos[11:0]), 48'd200);
    frames(25);
    cmp("d_dir_hold", 48'(bus.direction), 48'd0);
    // fire held for 40 frames gives one attack
    set_p(0, 2'b11, 12'd100, 12'd200);
    bus.fire = 2'b01;
    n_act = 0;
    for (int k = 0; k < 40; k++) begin
      frame();
      if (bus.attack_active[0]) n_act++;
    end
    cmp("e_once", 48'(n_act), 48'd8);
    bus.fire = 2'b00;
    cyc();
    set_p(0, 2'b01, 12'd100, 12'd100);
    bus.fire = 2'b01;
    frame();
    cmp("e_second", 48'(bus.attack_active), 48'd1);
    cmp("e_dir", 48'(bus.direction), 48'd0);
    bus.fire = 2'b00;
    frames(2);
    repeat (3) cyc();
    // asynchronous reset in the middle of an attack
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("r_x", 48'(bus.x_pos), 48'h000000FA0FA0);
    cmp("r_y", 48'(bus.y_pos), 48'h000000FA0FA0);
    cmp("r_dir", 48'(bus.direction), 48'd1);
    cmp("r_act", 48'(bus.attack_active), 48'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    frames(2);
    cmp("r_after", 48'(bus.attack_active), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
